// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency memory port between instruction fetch and data access.
// Data has priority, bounded so that fetch waits for at most STARVE consecutive data grants.
module mem_port_arbiter #(
    parameter int LAT    = 2,
    parameter int STARVE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [15:0] conflict_cnt
);
    typedef enum logic [1:0] {IDLE, RD_I, RD_D} state_t;

    state_t     state, stateNext;
    logic [3:0] latCnt, starveCnt;
    logic       ifReqM, dReqM, finish, arb, grantI, grantD;

    always_comb begin
        // A port whose ready pulse is showing is masked so its held request is not re-granted.
        ifReqM    = if_req & ~if_ready;
        dReqM     = d_req & ~d_ready;
        finish    = (state != IDLE) && (latCnt == 4'd0);
        arb       = (state == IDLE) || finish;
        grantD    = arb && dReqM && (!ifReqM || (starveCnt < 4'(STARVE)));
        grantI    = arb && !grantD && ifReqM;
        stateNext = state;
        if (finish)
            stateNext = IDLE;
        if (grantI)
            stateNext = RD_I;
        else if (grantD && !d_we)
            stateNext = RD_D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            latCnt       <= '0;
            starveCnt    <= '0;
            if_rdata     <= '0;
            if_ready     <= 1'b0;
            d_rdata      <= '0;
            d_ready      <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_byte     <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state    <= stateNext;
            busy     <= (stateNext != IDLE);
            mem_en   <= grantI || grantD;
            if_ready <= finish && (state == RD_I);
            d_ready  <= (finish && (state == RD_D)) || (grantD && d_we);

            if (finish && (state == RD_I))
                if_rdata <= mem_rdata;
            if (finish && (state == RD_D))
                d_rdata <= mem_rdata;

            if (grantI || (grantD && !d_we))
                latCnt <= 4'(LAT);
            else if ((state != IDLE) && (latCnt != 4'd0))
                latCnt <= latCnt - 4'd1;

            if (grantI) begin
                mem_we    <= 1'b0;
                mem_byte  <= 1'b0;
                mem_addr  <= {if_addr[31:2], 2'b00};
                mem_wdata <= '0;
                starveCnt <= '0;
            end else if (grantD) begin
                mem_we    <= d_we;
                mem_byte  <= d_byte;
                mem_addr  <= d_byte ? d_addr : {d_addr[31:2], 2'b00};
                mem_wdata <= d_wdata;
                if (!ifReqM)
                    starveCnt <= '0;
                else if (starveCnt != 4'hF)
                    starveCnt <= starveCnt + 4'd1;
            end

            if (arb && ifReqM && dReqM && (conflict_cnt != 16'hFFFF))
                conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at LAT=2/STARVE=4, one at LAT=1.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 0, d_req = 0, d_we = 0, d_byte = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_en, mem_we, mem_byte, busy;
    logic [15:0] conflict_cnt;

    logic        bIfReq = 0, bDReq = 0, bDWe = 0, bDByte = 0;
    logic [31:0] bIfAddr = 0, bDAddr = 0, bDWdata = 0, bMemRdata = 0;
    logic [31:0] bIfRdata, bDRdata, bMemAddr, bMemWdata;
    logic        bIfReady, bDReady, bMemEn, bMemWe, bMemByte, bBusy;
    logic [15:0] bConflict;

    int nCmp = 0, nBad = 0;

    mem_port_arbiter #(.LAT(2), .STARVE(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.LAT(1), .STARVE(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(bIfReq), .if_addr(bIfAddr), .if_rdata(bIfRdata), .if_ready(bIfReady),
        .d_req(bDReq), .d_we(bDWe), .d_byte(bDByte), .d_addr(bDAddr), .d_wdata(bDWdata),
        .d_rdata(bDRdata), .d_ready(bDReady),
        .mem_en(bMemEn), .mem_we(bMemWe), .mem_byte(bMemByte), .mem_addr(bMemAddr),
        .mem_wdata(bMemWdata), .mem_rdata(bMemRdata),
        .busy(bBusy), .conflict_cnt(bConflict)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        string expOrd;
        int    g;
        logic  sawReady;
        logic [5:0] expEn, expRdy;

        // reset
        tick(); tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_ready", {if_ready, d_ready}, 0);
        chk("rst_conflict", conflict_cnt, 0);
        rst = 0;

        // fetch read, LAT=2, unaligned address; request dropped early
        if_req = 1; if_addr = 32'h0000_1003; mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("f_mem_en", mem_en, 1);
        chk("f_mem_addr", mem_addr, 32'h0000_1000);
        chk("f_we_byte", {mem_we, mem_byte}, 0);
        chk("f_busy0", busy, 1);
        tick();
        chk("f_en_off", mem_en, 0);
        chk("f_busy1", busy, 1);
        if_req = 0;
        tick();
        chk("f_busy2", busy, 1);
        chk("f_no_early", {if_ready, if_rdata}, 0);
        tick();
        chk("f_ready", if_ready, 1);
        chk("f_rdata", if_rdata, 32'hDEAD_BEEF);
        chk("f_busy3", busy, 0);
        tick();
        chk("f_ready_pulse", if_ready, 0);
        chk("f_rdata_hold", if_rdata, 32'hDEAD_BEEF);

        // data byte write, request held one extra cycle
        d_req = 1; d_we = 1; d_byte = 1; d_addr = 32'h23; d_wdata = 32'hAB;
        tick();
        chk("w_cmd", {mem_en, mem_we, mem_byte}, 3'b111);
        chk("w_addr", mem_addr, 32'h23);
        chk("w_wdata", mem_wdata, 32'hAB);
        chk("w_ready", d_ready, 1);
        chk("w_rdata_keep", d_rdata, 0);
        chk("w_busy", busy, 0);
        tick();
        chk("w_no_dup", {mem_en, d_ready}, 0);
        // word write clears the low address bits
        d_byte = 0; d_addr = 32'h27; d_wdata = 32'h1234_5678;
        tick();
        chk("ww_addr", mem_addr, 32'h24);
        chk("ww_byte", {mem_en, mem_we, mem_byte}, 3'b110);
        d_req = 0; d_we = 0;
        tick();
        chk("ww_idle", mem_en, 0);
        chk("ww_conflict", conflict_cnt, 0);

        // both held, data reads: bounded data priority
        expOrd = "DDDDIDDDDI";
        if_req = 1; if_addr = 32'h2000; d_req = 1; d_addr = 32'h3000; mem_rdata = 32'h5555_AAAA;
        g = 0;
        for (int c = 0; c < 60 && g < 10; c++) begin
            tick();
            if (mem_en) begin
                chk($sformatf("order%0d", g), (mem_addr == 32'h3000) ? 32'h44 : 32'h49,
                    {24'h0, expOrd[g]});
                g++;
            end
        end
        chk("grants", g, 10);
        chk("conflict10", conflict_cnt, 16'd10);
        if_req = 0; d_req = 0;
        repeat (5) tick();
        chk("s_busy", busy, 0);
        chk("s_conflict_keep", conflict_cnt, 16'd10);
        chk("s_if_rdata", if_rdata, 32'h5555_AAAA);
        chk("s_d_rdata", d_rdata, 32'h5555_AAAA);

        // reset in the middle of a data read
        d_req = 1; d_addr = 32'h502;
        tick();
        chk("r_mem_en", mem_en, 1);
        chk("r_mem_addr", mem_addr, 32'h500);
        d_req = 0; rst = 1;
        tick();
        chk("r_outs", {mem_en, busy, if_ready, d_ready, mem_we, mem_byte}, 0);
        chk("r_data", d_rdata | if_rdata | mem_addr, 0);
        chk("r_conflict", conflict_cnt, 0);
        rst = 0; mem_rdata = 32'hCAFE_0000;
        sawReady = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            sawReady |= d_ready;
        end
        chk("r_no_ready", {sawReady, d_rdata}, 0);

        // conflict counter saturation
        force dut.conflict_cnt = 16'hFFFD;
        #1;
        release dut.conflict_cnt;
        if_req = 1; d_req = 1;
        tick();
        chk("sat_step", conflict_cnt, 16'hFFFE);
        repeat (9) tick();
        chk("sat_hold", conflict_cnt, 16'hFFFF);
        if_req = 0; d_req = 0;
        repeat (4) tick();

        // LAT=1, fetch held: one command every two cycles
        bIfReq = 1; bIfAddr = 32'h41; bMemRdata = 32'h7777_0001;
        expEn  = 6'b010101;  // bit i = sample i
        expRdy = 6'b010100;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("l1_en%0d", i), bMemEn, expEn[i]);
            chk($sformatf("l1_rdy%0d", i), bIfReady, expRdy[i]);
        end
        chk("l1_addr", bMemAddr, 32'h40);
        chk("l1_rdata", bIfRdata, 32'h7777_0001);
        bIfReq = 0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
